// File: rtl/fir_stream_ctrl_if.sv
// ----------------------------------------------------------------------------
// fir_stream_ctrl_if
// Bundles the three streams the FIR stream controller talks to:
//   - upstream sample stream : in_valid/in_ready/in_data/in_last
//   - attached FIR datapath  : fir_en/fir_data_in/fir_data_out
//   - downstream result FIFO : out_valid/out_ready/out_data/out_last
// modport master : the controller side (accepts samples, drives the FIR,
//                  presents results).
// modport slave  : the environment side (sample source, FIR, consumer).
// ----------------------------------------------------------------------------
interface fir_stream_ctrl_if #(
    parameter int DATA_W = 8,
    parameter int OUT_W  = 9
);
    logic                     in_valid;
    logic                     in_ready;
    logic signed [DATA_W-1:0] in_data;
    logic                     in_last;

    logic                     fir_en;
    logic signed [DATA_W-1:0] fir_data_in;
    logic signed [OUT_W-1:0]  fir_data_out;

    logic                     out_valid;
    logic                     out_ready;
    logic signed [OUT_W-1:0]  out_data;
    logic                     out_last;

    modport master (
        input  in_valid, in_data, in_last, fir_data_out, out_ready,
        output in_ready, fir_en, fir_data_in, out_valid, out_data, out_last
    );

    modport slave (
        output in_valid, in_data, in_last, fir_data_out, out_ready,
        input  in_ready, fir_en, fir_data_in, out_valid, out_data, out_last
    );
endinterface

// File: rtl/fir_stream_ctrl.sv
// ----------------------------------------------------------------------------
// fir_stream_ctrl
// Turns a valid/ready sample stream into step enables for an attached
// fixed-coefficient FIR, tags every FIR step so that only results of real
// samples are kept, buffers those results in a first-word-fall-through FIFO
// with backpressure, and flushes the FIR with zeros after the last sample of
// a block so the tail results emerge.
//
// Ports:
//   clk    : clock, rising edge
//   rst_b  : asynchronous active-low reset (shared with the FIR)
//   bus    : fir_stream_ctrl_if.master (sample in, FIR side, result out)
//   busy   : not in RUN, or any accepted sample not yet popped downstream
// ----------------------------------------------------------------------------
module fir_stream_ctrl #(
    parameter int DATA_W        = 8,
    parameter int OUT_W         = 9,
    parameter int LATENCY       = 2,
    parameter int NUM_TAPS      = 5,
    parameter int FIFO_DEPTH    = 4,
    parameter bit CLEAR_ON_LAST = 1'b1
) (
    input  logic              clk,
    input  logic              rst_b,
    fir_stream_ctrl_if.master bus,
    output logic              busy
);

    // Flush length: enough zero steps to push out the last result, and when
    // clearing is requested, also enough to wash every tap to zero.
    localparam int FLUSH_LEN = CLEAR_ON_LAST ?
                               ((LATENCY > NUM_TAPS) ? LATENCY : NUM_TAPS) : LATENCY;
    localparam int FL_W      = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam int OCC_W     = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } state_t;

    state_t                  state, state_next;
    logic [FL_W-1:0]         flush_cnt, flush_cnt_next;
    logic                    accept;
    logic                    has_space;

    logic [LATENCY-1:0]      tag_valid, tag_last;
    logic [LATENCY-1:0]      tag_valid_shift, tag_last_shift;
    logic                    push_pending;
    logic                    push, pop;

    logic [OCC_W-1:0]        occupancy;
    logic [OCC_W-1:0]        fifo_cnt;
    logic [PTR_W-1:0]        wr_ptr, rd_ptr;
    logic signed [OUT_W-1:0] data_mem [FIFO_DEPTH];
    logic                    last_mem [FIFO_DEPTH];

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(FIFO_DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    // Occupancy is a reservation count: it rises when a sample is accepted
    // and falls only when its result is popped, so every result still inside
    // the FIR, waiting in push_pending or sitting in the FIFO already owns a
    // FIFO slot. That is why FLUSH never needs a space check.
    assign has_space = occupancy < OCC_W'(FIFO_DEPTH);

    // ------------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= RUN;
            flush_cnt <= '0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    // ------------------------------------------------------------------------
    // FSM: next state and stream-side outputs
    // ------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        state_next      = state;
        flush_cnt_next  = flush_cnt;
        accept          = 1'b0;
        bus.in_ready    = 1'b0;
        bus.fir_en      = 1'b0;
        bus.fir_data_in = '0;

        case (state)
            RUN: begin
                bus.in_ready = has_space;
                accept       = bus.in_valid & has_space;
                bus.fir_en   = accept;
                if (accept) begin
                    bus.fir_data_in = bus.in_data;
                    if (bus.in_last) begin
                        state_next     = FLUSH;
                        flush_cnt_next = '0;
                    end
                end
            end
            FLUSH: begin
                bus.fir_en = 1'b1;
                if (flush_cnt == FL_W'(FLUSH_LEN - 1)) begin
                    state_next = RUN;
                end else begin
                    flush_cnt_next = flush_cnt + 1'b1;
                end
            end
            default: state_next = RUN;
        endcase
    end

    // ------------------------------------------------------------------------
    // Tag pipeline: one {valid, last} entry per FIR step, advancing only when
    // the FIR steps, so tags stay aligned with the FIR's internal samples.
    // Flush zeros enter as {0, 0} because accept is low in FLUSH.
    // ------------------------------------------------------------------------
    assign tag_valid_shift = (tag_valid << 1) | LATENCY'(accept);
    assign tag_last_shift  = (tag_last << 1) | LATENCY'(accept & bus.in_last);

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            tag_valid    <= '0;
            tag_last     <= '0;
            push_pending <= 1'b0;
        end else begin
            if (bus.fir_en) begin
                tag_valid <= tag_valid_shift;
                tag_last  <= tag_last_shift;
            end
            // The matching result lands on fir_data_out at this same edge,
            // so it is written one cycle later.
            push_pending <= bus.fir_en & tag_valid_shift[LATENCY-1];
        end
    end

    // push_pending always implies a valid last-stage tag; the tag's last bit
    // is still in place during the push cycle even if the FIR steps again.
    assign push = push_pending & tag_valid[LATENCY-1];
    assign pop  = bus.out_valid & bus.out_ready;

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            occupancy <= '0;
        end else begin
            case ({accept, pop})
                2'b10:   occupancy <= occupancy + 1'b1;
                2'b01:   occupancy <= occupancy - 1'b1;
                default: occupancy <= occupancy;
            endcase
        end
    end

    // ------------------------------------------------------------------------
    // Output FIFO, first-word-fall-through from registered storage
    // ------------------------------------------------------------------------
    // NOTE: this storage is reset on purpose: the head entry drives out_data
    // and out_last directly, and both must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                data_mem[i] <= '0;
                last_mem[i] <= 1'b0;
            end
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) begin
                data_mem[wr_ptr] <= bus.fir_data_out;
                last_mem[wr_ptr] <= tag_last[LATENCY-1];
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    assign bus.out_valid = (fifo_cnt != '0);
    assign bus.out_data  = data_mem[rd_ptr];
    assign bus.out_last  = last_mem[rd_ptr];

    assign busy = (state != RUN) || (occupancy != '0);

endmodule

// File: tb/tb_fir_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_fir_stream_ctrl
// Drives fir_stream_ctrl with directed and randomized sample blocks. A small
// FIR model (5 taps, coefficients 2,-2,4,-4,8, rounded >>2, two-step latency)
// plays the attached datapath. Expected results come from a block-level
// convolution of the accepted samples, queued in order and compared at every
// downstream pop.
// ----------------------------------------------------------------------------
module tb_fir_stream_ctrl;

    localparam int DATA_W     = 8;
    localparam int OUT_W      = 9;
    localparam int LATENCY    = 2;
    localparam int NUM_TAPS   = 5;
    localparam int FIFO_DEPTH = 4;
    localparam int COEF [NUM_TAPS] = '{2, -2, 4, -4, 8};

    typedef struct packed {
        int   data;
        logic last;
    } item_t;

    logic clk = 1'b0;
    logic rst_b = 1'b0;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_acc = 0;
    int first_acc_cyc = -1;
    int first_ov_cyc = -1;
    bit ov_seen = 1'b0;

    item_t pend  [$];   // samples still to be offered upstream
    item_t exp_q [$];   // expected results in output order
    item_t got_q [$];   // results actually popped (for directed checks)
    int    hist  [$];   // samples of the current block, oldest first
    item_t mon_e;

    fir_stream_ctrl_if #(.DATA_W(DATA_W), .OUT_W(OUT_W)) bus ();

    fir_stream_ctrl #(
        .DATA_W        (DATA_W),
        .OUT_W         (OUT_W),
        .LATENCY       (LATENCY),
        .NUM_TAPS      (NUM_TAPS),
        .FIFO_DEPTH    (FIFO_DEPTH),
        .CLEAR_ON_LAST (1'b1)
    ) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus.master),
        .busy  (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // ------------------------------------------------------------------------
    // Attached FIR: taps capture on en, output register updates on en from
    // the taps as they were before the edge (sample -> result in 2 steps).
    // ------------------------------------------------------------------------
    logic signed [DATA_W-1:0] taps [NUM_TAPS];

    function automatic logic signed [OUT_W-1:0] fir_sum();
        int acc = 0;
        for (int k = 0; k < NUM_TAPS; k++) acc += COEF[k] * int'(taps[k]);
        return OUT_W'((acc + 2) >>> 2);
    endfunction

    always @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int k = 0; k < NUM_TAPS; k++) taps[k] <= '0;
            bus.fir_data_out <= '0;
        end else if (bus.fir_en) begin
            bus.fir_data_out <= fir_sum();
            taps[0] <= bus.fir_data_in;
            for (int k = 1; k < NUM_TAPS; k++) taps[k] <= taps[k-1];
        end
    end

    // ------------------------------------------------------------------------
    // Checking helpers and reference model
    // ------------------------------------------------------------------------
    task automatic check(input string tag, input logic signed [31:0] obs,
                         input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // y[n] = round(sum c[k] * x[n-k] / 4), with x zero before the block start
    function automatic int ref_out(input int h[$]);
        int acc = 0;
        int n = h.size();
        for (int k = 0; k < NUM_TAPS && k < n; k++) acc += COEF[k] * h[n-1-k];
        return (acc + 2) >>> 2;
    endfunction

    task automatic model_accept(input item_t it);
        item_t e;
        hist.push_back(it.data);
        e.data = ref_out(hist);
        e.last = it.last;
        exp_q.push_back(e);
        if (it.last) hist.delete();
    endtask

    // Downstream monitor: every pop is compared to the next expected result.
    always @(negedge clk) begin
        if (rst_b && bus.out_valid && !ov_seen) begin
            ov_seen      = 1'b1;
            first_ov_cyc = cyc;
        end
        if (rst_b && bus.out_valid && bus.out_ready) begin
            got_q.push_back('{data: int'(bus.out_data), last: bus.out_last});
            if (exp_q.size() == 0) begin
                check("unexpected_output", 1, 0);
            end else begin
                mon_e = exp_q.pop_front();
                check("out_data", bus.out_data, mon_e.data);
                check("out_last", bus.out_last, mon_e.last);
            end
        end
    end

    // Offer queued samples for up to max_cycles; inputs change 1 after posedge.
    task automatic drive(input int max_cycles, input bit until_empty, input bit rand_ready);
        bit took;
        for (int i = 0; i < max_cycles; i++) begin
            if (until_empty && pend.size() == 0) break;
            if (rand_ready) bus.out_ready = 1'($urandom_range(0, 1));
            bus.in_valid = (pend.size() != 0);
            if (pend.size() != 0) begin
                bus.in_data = DATA_W'(pend[0].data);
                bus.in_last = pend[0].last;
            end else begin
                bus.in_data = '0;
                bus.in_last = 1'b0;
            end
            @(negedge clk);
            took = bus.in_valid && bus.in_ready;
            if (took) begin
                check("accept_fir_en", bus.fir_en, 1);
                check("accept_fir_data", bus.fir_data_in, pend[0].data);
                model_accept(pend[0]);
                n_acc++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            @(posedge clk);
            #1;
            if (took) void'(pend.pop_front());
        end
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = '0;
        if (until_empty) check("drive_budget", pend.size(), 0);
    endtask

    task automatic wait_idle(input int budget);
        int n = 0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        while ((busy || bus.out_valid) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle_busy", busy, 0);
        check("idle_expected_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic impulse_block(input string tag);
        int imp_exp [5] = '{32, -32, 64, -64, 128};
        got_q.delete();
        ov_seen       = 1'b0;
        first_acc_cyc = -1;
        pend.push_back('{data: 64, last: 1'b0});
        for (int i = 0; i < 3; i++) pend.push_back('{data: 0, last: 1'b0});
        pend.push_back('{data: 0, last: 1'b1});
        drive(50, 1'b1, 1'b0);
        wait_idle(100);
        check({tag, "_count"}, got_q.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < got_q.size()) begin
                check({tag, "_data"}, got_q[i].data, imp_exp[i]);
                check({tag, "_last"}, got_q[i].last, (i == 4) ? 1 : 0);
            end
        end
        check({tag, "_first_valid_latency"}, first_ov_cyc - first_acc_cyc, 3);
    endtask

    // ------------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------------
    initial begin
        int len;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b1;

        // Reset values
        @(negedge clk);
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_fir_en", bus.fir_en, 0);
        check("rst_fir_data_in", bus.fir_data_in, 0);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_out_last", bus.out_last, 0);
        check("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;

        // Impulse block
        impulse_block("impulse");

        // Backpressure: ten samples offered with the consumer stalled
        bus.out_ready = 1'b0;
        got_q.delete();
        n_acc = 0;
        for (int i = 0; i < 10; i++)
            pend.push_back('{data: int'($urandom_range(0, 100)) - 50, last: (i == 9)});
        drive(20, 1'b0, 1'b0);
        check("bp_accepted", n_acc, FIFO_DEPTH);
        @(negedge clk);
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_out_valid", bus.out_valid, 1);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("bp_in_ready_pop_cycle", bus.in_ready, 0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("bp_in_ready_after_pop", bus.in_ready, 1);
        @(posedge clk);
        #1;
        drive(200, 1'b1, 1'b0);
        wait_idle(200);
        check("bp_count", got_q.size(), 10);

        // Single-sample blocks, back to back: flush shape and no leakage
        got_q.delete();
        for (int b = 0; b < 2; b++) begin
            pend.push_back('{data: 64, last: 1'b1});
            drive(50, 1'b1, 1'b0);
            for (int i = 0; i < 5; i++) begin
                @(negedge clk);
                check("flush_fir_en", bus.fir_en, 1);
                check("flush_fir_data_zero", bus.fir_data_in, 0);
                check("flush_in_ready", bus.in_ready, 0);
                check("flush_busy", busy, 1);
                @(posedge clk);
                #1;
            end
            @(negedge clk);
            check("post_flush_in_ready", bus.in_ready, 1);
            @(posedge clk);
            #1;
        end
        wait_idle(100);
        check("single_count", got_q.size(), 2);
        for (int i = 0; i < 2; i++) begin
            if (i < got_q.size()) begin
                check("single_data", got_q[i].data, 32);
                check("single_last", got_q[i].last, 1);
            end
        end

        // Random blocks with random downstream stalls
        for (int b = 0; b < 6; b++) begin
            len = int'($urandom_range(1, 8));
            for (int i = 0; i < len; i++)
                pend.push_back('{data: int'($urandom_range(0, 100)) - 50, last: (i == len - 1)});
        end
        drive(2000, 1'b1, 1'b1);
        wait_idle(200);

        // Reset in the middle of a block
        for (int i = 0; i < 6; i++)
            pend.push_back('{data: int'($urandom_range(0, 100)) - 50, last: 1'b0});
        drive(3, 1'b0, 1'b0);
        #2;
        rst_b = 1'b0;
        pend.delete();
        exp_q.delete();
        hist.delete();
        @(negedge clk);
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_busy", busy, 0);
        check("midrst_out_last", bus.out_last, 0);
        @(posedge clk);
        #1;
        rst_b = 1'b1;
        @(posedge clk);
        #1;
        impulse_block("impulse_after_reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1, "watchdog expired");
    end

endmodule
